// File: rtl/lm07_spi_slave_if.sv
// SPI pin bundle between an LM07-style master and the slave block.
// CS/SCK come from the master; SIO and its pad enable go back to it.
interface lm07_spi_slave_if;
   logic CS;
   logic SCK;
   logic SIO;
   logic sio_oe;

   modport master (
      output CS,
      output SCK,
      input  SIO,
      input  sio_oe
   );

   modport slave (
      input  CS,
      input  SCK,
      output SIO,
      output sio_oe
   );
endinterface

// File: rtl/lm07_spi_slave.sv
// LM07-compatible SPI temperature slave: synchronizes CS/SCK into SYSCLK
// and shifts out a held 13-bit temperature followed by PAD_BITS ones.
module lm07_spi_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int PAD_BITS    = 3
) (
   input  logic                SYSCLK,
   input  logic                RSTN,
   lm07_spi_slave_if.slave     spi,
   input  logic [12:0]         temp_in,
   input  logic                temp_ld,
   output logic                busy,
   output logic                frame_done
);

   localparam int FRAME_LEN = 13 + PAD_BITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [4:0] CNT_MAX  = 5'(FRAME_LEN);
   localparam logic [4:0] CNT_LAST = 5'(FRAME_LEN - 1);
   localparam logic [1:0] FLUSH_N  = 2'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sck_prev_q, sck_prev_d;
   logic [1:0]             flush_q, flush_d;
   logic                   armed_q, armed_d;

   logic [1:0]             state_q, state_d;
   logic [FRAME_LEN-1:0]   shift_q, shift_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic [12:0]            hold_q, hold_d;
   logic [12:0]            pend_q, pend_d;
   logic                   pend_flag_q, pend_flag_d;

   logic cs_s;
   logic sck_s;
   logic cs_fall;
   logic cs_rise;
   logic sck_fall;

   assign cs_s  = cs_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];

   // Falls are ignored until CS has been seen high on post-reset samples,
   // so a CS held low across reset cannot start a frame.
   assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
   assign cs_rise  = ~cs_prev_q & cs_s;
   assign sck_fall = sck_prev_q & ~sck_s;

   always_comb begin
      cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi.CS};
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi.SCK};
      cs_prev_d  = cs_s;
      sck_prev_d = sck_s;
      flush_d    = (flush_q == FLUSH_N) ? flush_q : flush_q + 2'd1;
      armed_d    = armed_q | ((flush_q == FLUSH_N) & cs_s);
   end

   // Holding register with a one-deep pending slot for loads during a frame.
   always_comb begin
      hold_d      = hold_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (state_q == ST_IDLE) begin
         if (temp_ld) begin
            hold_d      = temp_in;
            pend_flag_d = 1'b0;
         end else if (pend_flag_q) begin
            hold_d      = pend_q;
            pend_flag_d = 1'b0;
         end
      end else if (temp_ld) begin
         pend_d      = temp_in;
         pend_flag_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_SHIFT;
               shift_d = {hold_q, {PAD_BITS{1'b1}}};
               cnt_d   = 5'd0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               shift_d = '1;
            end else if (sck_fall) begin
               shift_d = {shift_q[FRAME_LEN-2:0], 1'b1};
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 5'd1;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               shift_d = '1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            shift_d = '1;
         end
      endcase
   end

   always_ff @(posedge SYSCLK) begin
      if (!RSTN) begin
         cs_sync_q   <= '1;
         sck_sync_q  <= '0;
         cs_prev_q   <= 1'b1;
         sck_prev_q  <= 1'b0;
         flush_q     <= 2'd0;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         shift_q     <= '1;
         cnt_q       <= 5'd0;
         done_q      <= 1'b0;
         hold_q      <= 13'd0;
         pend_q      <= 13'd0;
         pend_flag_q <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sck_sync_q  <= sck_sync_d;
         cs_prev_q   <= cs_prev_d;
         sck_prev_q  <= sck_prev_d;
         flush_q     <= flush_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
      end
   end

   assign spi.SIO    = shift_q[FRAME_LEN-1];
   assign spi.sio_oe = (state_q != ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;

endmodule

// File: tb/tb_lm07_spi_slave.sv
// Directed bench for lm07_spi_slave: table of frames plus reset corner case.
// A behavioural SPI master toggles CS/SCK slowly and samples SIO on SCK rise.
module tb_lm07_spi_slave;

   localparam int SS   = 2;
   localparam int PAD  = 3;
   localparam int FLEN = 13 + PAD;
   localparam int HALF = 6;

   logic        clk;
   logic        rstn;
   logic [12:0] temp_in;
   logic        temp_ld;
   logic        busy;
   logic        frame_done;

   lm07_spi_slave_if spi ();

   lm07_spi_slave #(
      .SYNC_STAGES(SS),
      .PAD_BITS   (PAD)
   ) dut (
      .SYSCLK    (clk),
      .RSTN      (rstn),
      .spi       (spi),
      .temp_in   (temp_in),
      .temp_ld   (temp_ld),
      .busy      (busy),
      .frame_done(frame_done)
   );

   typedef struct {
      logic        pre;
      logic [12:0] pre_v;
      int          nfall;
      int          ld_at;
      logic [12:0] v1;
      logic [12:0] v2;
      logic        simul;
      logic [31:0] exp_bits;
      int          exp_done;
   } vec_t;

   vec_t tbl[9];

   int n_pass;
   int n_total;
   int done_cnt;
   int done_at;
   int fall_idx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         done_at  = fall_idx;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic load(input logic [12:0] v);
      temp_in = v;
      temp_ld = 1'b1;
      @(negedge clk);
      temp_ld = 1'b0;
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      logic [31:0] bits;
      int d0;
      bits     = '0;
      d0       = done_cnt;
      fall_idx = 0;
      if (v.pre) load(v.pre_v);
      if (v.simul) begin
         spi.SCK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      spi.CS  = 1'b0;
      spi.SCK = 1'b0;
      repeat (SS) @(posedge clk);
      #1;
      chk({tag, "_oe_early"}, 32'(spi.sio_oe), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_oe_on"}, 32'(spi.sio_oe), 32'd1);
      chk({tag, "_busy_on"}, 32'(busy), 32'd1);
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < v.nfall; i++) begin
         bits    = {bits[30:0], spi.SIO};
         spi.SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         spi.SCK  = 1'b0;
         fall_idx = fall_idx + 1;
         repeat (HALF) @(negedge clk);
         if (fall_idx == v.ld_at) load(v.v1);
         if (fall_idx == v.ld_at + 1 && v.ld_at != 0) load(v.v2);
      end
      chk({tag, "_bits"}, bits, v.exp_bits);
      spi.CS = 1'b1;
      repeat (SS) @(posedge clk);
      #1;
      chk({tag, "_oe_hold"}, 32'(spi.sio_oe), 32'd1);
      @(posedge clk);
      #1;
      chk({tag, "_oe_off"}, 32'(spi.sio_oe), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      chk({tag, "_sio_idle"}, 32'(spi.SIO), 32'd1);
      repeat (HALF) @(negedge clk);
      chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'(v.exp_done));
      if (v.exp_done == 1) chk({tag, "_done_at"}, 32'(done_at), 32'(FLEN));
   endtask

   initial begin
      vec_t rv;
      int   d0;
      n_pass   = 0;
      n_total  = 0;
      done_cnt = 0;
      done_at  = 0;
      fall_idx = 0;

      tbl[0] = '{1'b1, 13'h0190, 16, 0, 13'h0, 13'h0, 1'b0, 32'h0C87, 1};
      tbl[1] = '{1'b1, 13'h1E70, 16, 0, 13'h0, 13'h0, 1'b0, 32'hF387, 1};
      tbl[2] = '{1'b0, 13'h0000, 5, 0, 13'h0, 13'h0, 1'b0, 32'h001E, 0};
      tbl[3] = '{1'b0, 13'h0000, 16, 0, 13'h0, 13'h0, 1'b0, 32'hF387, 1};
      tbl[4] = '{1'b1, 13'h0190, 16, 6, 13'h0AAA, 13'h0050, 1'b0,
                 32'h0C87, 1};
      tbl[5] = '{1'b0, 13'h0000, 16, 0, 13'h0, 13'h0, 1'b0, 32'h0287, 1};
      tbl[6] = '{1'b1, 13'h0190, 20, 0, 13'h0, 13'h0, 1'b0, 32'hC87F, 1};
      tbl[7] = '{1'b1, 13'h1555, 16, 0, 13'h0, 13'h0, 1'b1, 32'hAAAF, 1};
      tbl[8] = '{1'b1, 13'h0000, 16, 0, 13'h0, 13'h0, 1'b0, 32'h0007, 1};

      rstn    = 1'b0;
      spi.CS  = 1'b1;
      spi.SCK = 1'b0;
      temp_in = 13'h0;
      temp_ld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sio", 32'(spi.SIO), 32'd1);
      chk("rst_oe", 32'(spi.sio_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_frame(tbl[i], $sformatf("v%0d", i));
      end

      // Reset in the middle of a frame, CS kept low through and after it.
      d0 = done_cnt;
      load(13'h0ABC);
      spi.CS = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         spi.SCK = 1'b1;
         repeat (HALF) @(negedge clk);
         spi.SCK = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      chk("mid_oe_before", 32'(spi.sio_oe), 32'd1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_sio", 32'(spi.SIO), 32'd1);
      chk("mid_rst_oe", 32'(spi.sio_oe), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      chk("post_rst_cs_low_oe", 32'(spi.sio_oe), 32'd0);
      chk("post_rst_ndone", 32'(done_cnt - d0), 32'd0);
      spi.CS = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      rv = '{1'b0, 13'h0000, 16, 0, 13'h0, 13'h0, 1'b0, 32'h0007, 1};
      run_frame(rv, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
